// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external RV32I ALU between N_REQ requesters
module alu_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_op1,
  input  logic [32*N_REQ-1:0]  req_op2,
  input  logic [4*N_REQ-1:0]   req_aluop,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  output logic [3:0]           alu_aluop,
  input  logic [31:0]          alu_res,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_res,
  output logic                 rsp_err
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             iss_valid_q, iss_valid_d;
  logic [IW-1:0]    iss_id_q, iss_id_d;
  logic [31:0]      iss_op1_q, iss_op1_d;
  logic [31:0]      iss_op2_q, iss_op2_d;
  logic [3:0]       iss_aluop_q, iss_aluop_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_res_q, rsp_res_d;
  logic             rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0] rot_valid;
  logic             gnt_found;
  logic [IW-1:0]    gnt_id;
  logic [IW:0]      gnt_sum;
  logic [IW:0]      ptr_nxt;
  logic [31:0]      sel_op1, sel_op2;
  logic [3:0]       sel_aluop;
  logic             rsp_free, iss_free, iss_adv, accept, iss_illegal;

  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1101: is_illegal = 1'b0;
      default:                                     is_illegal = 1'b1;
    endcase
  endfunction

  // Round-robin grant: rotate request vector so ptr sits at bit 0, take the first set bit.
  always_comb begin
    rot_valid = N_REQ'({req_valid, req_valid} >> ptr_q);
    gnt_found = 1'b0;
    gnt_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && rot_valid[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, ptr_q} + (IW+1)'(k);
      end
    end
    if (gnt_sum >= (IW+1)'(N_REQ)) begin
      gnt_sum = gnt_sum - (IW+1)'(N_REQ);
    end
    gnt_id = gnt_sum[IW-1:0];
  end

  // Mux the granted requester's operands.
  always_comb begin
    sel_op1   = '0;
    sel_op2   = '0;
    sel_aluop = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == IW'(i)) begin
        sel_op1   = req_op1[32*i +: 32];
        sel_op2   = req_op2[32*i +: 32];
        sel_aluop = req_aluop[4*i +: 4];
      end
    end
  end

  // Handshake and pipeline-advance conditions; rsp_valid is one-hot so the AND finds the owner.
  always_comb begin
    rsp_free    = (rsp_valid_q == '0) || ((rsp_valid_q & rsp_ready) != '0);
    iss_free    = !iss_valid_q || rsp_free;
    iss_adv     = iss_valid_q && rsp_free;
    accept      = gnt_found && iss_free && !reset;
    iss_illegal = is_illegal(iss_aluop_q);
    req_ready   = accept ? (N_REQ'(1) << gnt_id) : '0;
  end

  // Next-state for pointer, ISS and RSP stages.
  always_comb begin
    ptr_nxt     = {1'b0, gnt_id} + (IW+1)'(1);
    ptr_d       = ptr_q;
    iss_valid_d = iss_valid_q && !iss_adv;
    iss_id_d    = iss_id_q;
    iss_op1_d   = iss_op1_q;
    iss_op2_d   = iss_op2_q;
    iss_aluop_d = iss_aluop_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;

    if (accept) begin
      ptr_d       = (ptr_nxt == (IW+1)'(N_REQ)) ? '0 : ptr_nxt[IW-1:0];
      iss_valid_d = 1'b1;
      iss_id_d    = gnt_id;
      iss_op1_d   = sel_op1;
      iss_op2_d   = sel_op2;
      iss_aluop_d = sel_aluop;
    end

    if (iss_adv) begin
      rsp_valid_d = N_REQ'(1) << iss_id_q;
      rsp_res_d   = iss_illegal ? 32'h0 : alu_res;
      rsp_err_d   = iss_illegal;
    end else if (rsp_free) begin
      rsp_valid_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_id_q    <= '0;
      iss_op1_q   <= '0;
      iss_op2_q   <= '0;
      iss_aluop_q <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_id_q    <= iss_id_d;
      iss_op1_q   <= iss_op1_d;
      iss_op2_q   <= iss_op2_d;
      iss_aluop_q <= iss_aluop_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_op1   = iss_op1_q;
  assign alu_op2   = iss_op2_q;
  assign alu_aluop = iss_aluop_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  localparam int N_REQ = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_op1;
  logic [32*N_REQ-1:0] req_op2;
  logic [4*N_REQ-1:0]  req_aluop;
  logic [31:0]         alu_op1;
  logic [31:0]         alu_op2;
  logic [3:0]          alu_aluop;
  logic [31:0]         alu_res;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [31:0]         rsp_res;
  logic                rsp_err;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N_REQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_aluop(req_aluop),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_err(rsp_err)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_op1, alu_op2, alu_aluop);

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluop;
    logic [31:0] exp_res;
    logic        exp_err;
    int          lat;
  } op_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
    int          acc;
    int          lat;
  } sb_t;

  op_t pend0[$];
  op_t pend1[$];
  sb_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_ptr = 0;
  logic rst_var = 1'b1;
  logic [1:0] rr_var = 2'b11;
  logic post_rst = 1'b0;
  logic held_v = 1'b0;
  logic [31:0] held_res;
  logic held_err;
  logic stall_v = 1'b0;
  logic [31:0] saved_op1, saved_op2;
  logic [3:0] saved_aluop;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] exp_res, input logic exp_err, input int lat);
    op_t o;
    o.op1 = a; o.op2 = b; o.aluop = op; o.exp_res = exp_res; o.exp_err = exp_err; o.lat = lat;
    if (r == 0) pend0.push_back(o);
    else        pend1.push_back(o);
  endtask

  task automatic add_alu(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    add_op(r, a, b, op, alu_f(a, b, op), 1'b0, 0);
  endtask

  task automatic drive();
    reset     = rst_var;
    rsp_ready = rr_var;
    req_valid = {pend1.size() > 0, pend0.size() > 0};
    if (pend0.size() > 0) begin
      req_op1[31:0] = pend0[0].op1; req_op2[31:0] = pend0[0].op2; req_aluop[3:0] = pend0[0].aluop;
    end else begin
      req_op1[31:0] = '0; req_op2[31:0] = '0; req_aluop[3:0] = '0;
    end
    if (pend1.size() > 0) begin
      req_op1[63:32] = pend1[0].op1; req_op2[63:32] = pend1[0].op2; req_aluop[7:4] = pend1[0].aluop;
    end else begin
      req_op1[63:32] = '0; req_op2[63:32] = '0; req_aluop[7:4] = '0;
    end
  endtask

  task automatic accept_from(input int r);
    op_t o;
    sb_t e;
    if (r == 0) begin o = pend0[0]; void'(pend0.pop_front()); end
    else        begin o = pend1[0]; void'(pend1.pop_front()); end
    e.id = 2'b01 << r; e.res = o.exp_res; e.err = o.exp_err; e.acc = cyc; e.lat = o.lat;
    sb.push_back(e);
    exp_ptr = 1 - r;
  endtask

  task automatic step();
    logic rsp_any, rsp_blk, iss_occ;
    logic [1:0] exp_rdy;
    int g;
    sb_t e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("ready_in_reset", 32'(req_ready), 32'h0);
      sb.delete();
      exp_ptr  = 0;
      post_rst = 1'b1;
      held_v   = 1'b0;
      stall_v  = 1'b0;
    end else begin
      if (post_rst) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_alu_op1", alu_op1, 32'h0);
        chk("rst_alu_op2", alu_op2, 32'h0);
        chk("rst_alu_aluop", 32'(alu_aluop), 32'h0);
        chk("rst_rsp_res", rsp_res, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        if (req_valid[0]) chk("first_grant", 32'(req_ready), 32'h1);
        post_rst = 1'b0;
      end
      rsp_any = (rsp_valid != '0);
      rsp_blk = rsp_any && ((rsp_valid & rsp_ready) == '0);
      iss_occ = (sb.size() > (rsp_any ? 1 : 0));
      if (stall_v) begin
        chk("stall_alu_op1", alu_op1, saved_op1);
        chk("stall_alu_op2", alu_op2, saved_op2);
        chk("stall_alu_aluop", 32'(alu_aluop), 32'(saved_aluop));
      end
      stall_v = iss_occ && rsp_blk;
      saved_op1 = alu_op1; saved_op2 = alu_op2; saved_aluop = alu_aluop;

      exp_rdy = 2'b00;
      if (req_valid != '0 && (!iss_occ || !rsp_blk)) begin
        g = req_valid[exp_ptr] ? exp_ptr : 1 - exp_ptr;
        exp_rdy = 2'b01 << g;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));

      if (rsp_any) begin
        if (sb.size() == 0) begin
          chk("stale_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          e = sb[0];
          chk("rsp_id", 32'(rsp_valid), 32'(e.id));
          if (held_v) begin
            chk("rsp_hold_res", rsp_res, held_res);
            chk("rsp_hold_err", 32'(rsp_err), 32'(held_err));
          end
          if (!rsp_blk) begin
            chk("rsp_res", rsp_res, e.res);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.lat > 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            void'(sb.pop_front());
            held_v = 1'b0;
          end else begin
            held_v = 1'b1; held_res = rsp_res; held_err = rsp_err;
          end
        end
      end else begin
        held_v = 1'b0;
      end

      if (req_ready[0] && pend0.size() > 0) accept_from(0);
      else if (req_ready[1] && pend1.size() > 0) accept_from(1);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((pend0.size() + pend1.size() + sb.size()) != 0 && n < max) begin
      step();
      n++;
    end
    chk("idle", 32'(pend0.size() + pend1.size() + sb.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    drive();
    step(); step();
    rst_var = 1'b0;
    step();

    // basic add
    add_op(0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0, 2);
    run_until_idle(20);

    // fairness with both requesters streaming
    for (int i = 0; i < 4; i++) begin
      add_alu(0, 32'd100 + 32'(i), 32'd3 * 32'(i), 4'b0000);
      add_alu(1, 32'hF0F0_0000 + 32'(i), 32'h0000_FFFF, 4'b0100);
    end
    run_until_idle(40);

    // back-pressure for 3 cycles mid-stream
    for (int i = 0; i < 4; i++) begin
      add_alu(0, 32'h1000 + 32'(i), 32'd1, 4'b0110);
      add_alu(1, 32'h0000_00FF, 32'h0F + 32'(i), 4'b0111);
    end
    step(); step();
    rr_var = 2'b00;
    step(); step(); step();
    rr_var = 2'b11;
    run_until_idle(50);

    // op coverage with fixed expected values
    add_op(0, 32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, 1'b0, 2);
    run_until_idle(20);
    add_op(1, 32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0, 2);
    run_until_idle(20);
    add_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b0, 2);
    run_until_idle(20);
    add_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd0, 1'b0, 2);
    run_until_idle(20);
    add_op(0, 32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF, 1'b0, 2);
    run_until_idle(20);

    // illegal op then a normal one
    add_op(0, 32'd7, 32'd7, 4'b1111, 32'd0, 1'b1, 2);
    add_op(0, 32'd7, 32'd7, 4'b0000, 32'd14, 1'b0, 0);
    run_until_idle(20);

    // reset with ISS and RSP both full
    rr_var = 2'b00;
    add_op(0, 32'd11, 32'd1, 4'b0000, 32'd12, 1'b0, 0);
    add_op(0, 32'd21, 32'd1, 4'b0000, 32'd22, 1'b0, 0);
    n = 0;
    while (sb.size() < 2 && n < 10) begin step(); n++; end
    chk("fill_occupancy", 32'(sb.size()), 32'd2);
    add_alu(1, 32'd40, 32'd2, 4'b0000);
    add_alu(0, 32'd50, 32'd3, 4'b0000);
    step();
    rst_var = 1'b1;
    step();
    rst_var = 1'b0;
    rr_var  = 2'b11;
    step();
    run_until_idle(30);
    step(); step();
    chk("final_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
